// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory-stage access unit: store lane alignment, load extension, dbus handshake
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses skip the bus and raise adel/ades.
module memory_access (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [37:0] args,
   input  logic [31:0] addr,
   output logic        dreq_valid,
   output logic [31:0] dreq_addr,
   output logic [2:0]  dreq_size,
   output logic [3:0]  dreq_strobe,
   output logic [31:0] dreq_data,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   input  logic [31:0] dresp_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        resp_adel,
   output logic        resp_ades
);

   localparam logic [2:0] MSIZE1 = 3'd0;
   localparam logic [2:0] MSIZE2 = 3'd1;
   localparam logic [2:0] MSIZE4 = 3'd2;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t state, next_state;

   // args layout: {valid, write, sig (1 = signed), msize[2:0], data[31:0]}
   logic        a_valid, a_write, a_sig;
   logic [2:0]  a_msize;
   logic [31:0] a_data;
   assign a_valid = args[37];
   assign a_write = args[36];
   assign a_sig   = args[35];
   assign a_msize = args[34:32];
   assign a_data  = args[31:0];

   logic [1:0]  a_lane;
   logic [3:0]  a_strobe;
   logic [31:0] a_wdata;
   logic        misalign;
   logic        accept, capture;

   logic        write_q, sig_q;
   logic [1:0]  lane_q;
   logic [31:0] word_q;

   always_comb begin
      a_lane   = addr[1:0];
      a_strobe = 4'b1111;
      a_wdata  = a_data;
      misalign = 1'b0;
      if (a_msize == MSIZE2) begin
         a_lane[0] = 1'b0;
      end else if (a_msize != MSIZE1) begin
         a_lane = 2'b00;
      end
`ifdef MEM_ALIGN_CHECK_EN
      misalign = ((a_msize == MSIZE2) && addr[0]) ||
                 ((a_msize == MSIZE4) && (addr[1:0] != 2'b00));
`endif
      case (a_msize)
         MSIZE1: begin
            a_strobe = 4'b0001 << a_lane;
            a_wdata  = {4{a_data[7:0]}};
         end
         MSIZE2: begin
            a_strobe = 4'b0011 << {a_lane[1], 1'b0};
            a_wdata  = {2{a_data[15:0]}};
         end
         default: begin
            a_strobe = 4'b1111;
            a_wdata  = a_data;
         end
      endcase
   end

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      dreq_valid = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && a_valid) begin
               accept     = 1'b1;
               next_state = misalign ? RESP : REQ;
            end
         end
         REQ: begin
            dreq_valid = 1'b1;
            if (dresp_addr_ok) begin
               capture    = dresp_data_ok;
               next_state = dresp_data_ok ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (dresp_data_ok) begin
               capture    = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         dreq_addr   <= 32'd0;
         dreq_size   <= 3'd0;
         dreq_strobe <= 4'd0;
         dreq_data   <= 32'd0;
         write_q     <= 1'b0;
         sig_q       <= 1'b0;
         lane_q      <= 2'd0;
         word_q      <= 32'd0;
         resp_adel   <= 1'b0;
         resp_ades   <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            dreq_addr   <= addr;
            dreq_size   <= a_msize;
            dreq_strobe <= a_write ? a_strobe : 4'b0000;
            dreq_data   <= a_wdata;
            write_q     <= a_write;
            sig_q       <= a_sig;
            lane_q      <= a_lane;
            word_q      <= 32'd0;
            resp_adel   <= misalign & ~a_write;
            resp_ades   <= misalign & a_write;
         end
         if (capture) word_q <= dresp_data;
      end
   end

   // Extension is done from the captured word so dresp_* never reaches resp_* combinationally.
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   always_comb begin
      case (lane_q)
         2'd0:    ld_byte = word_q[7:0];
         2'd1:    ld_byte = word_q[15:8];
         2'd2:    ld_byte = word_q[23:16];
         default: ld_byte = word_q[31:24];
      endcase
      ld_half = lane_q[1] ? word_q[31:16] : word_q[15:0];
      case (dreq_size)
         MSIZE1:  resp_data = sig_q ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
         MSIZE2:  resp_data = sig_q ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
         default: resp_data = word_q;
      endcase
      if (write_q) resp_data = 32'd0;
   end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [37:0] args;
   logic [31:0] addr;
   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [31:0] dresp_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_adel;
   logic        resp_ades;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   memory_access dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
      .args(args), .addr(addr), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
      .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_adel(resp_adel), .resp_ades(resp_ades)
   );

   function automatic logic [37:0] mk(input logic wr, input logic sg, input logic [2:0] sz,
                                      input logic [31:0] d);
      return {1'b1, wr, sg, sz, d};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [37:0] a, input logic [31:0] ad);
      req_valid = 1'b1;
      args      = a;
      addr      = ad;
      step();
      req_valid = 1'b0;
      args      = '0;
   endtask

   task automatic ack_now(input logic [31:0] d);
      dresp_addr_ok = 1'b1;
      dresp_data_ok = 1'b1;
      dresp_data    = d;
      step();
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data    = 32'h5A5A5A5A;
   endtask

   task automatic handshake();
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; req_valid = 1'b0; args = '0; addr = '0;
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0; resp_ready = 1'b0;
      step(); step();
      check("rst_req_ready", req_ready, 1);
      check("rst_dreq_valid", dreq_valid, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_dreq_addr", dreq_addr, 0);
      check("rst_dreq_strobe", dreq_strobe, 0);
      check("rst_dreq_data", dreq_data, 0);
      check("rst_dreq_size", dreq_size, 0);
      check("rst_adel_ades", {resp_adel, resp_ades}, 0);
      resetn = 1'b1;
      step();

      // request with args.valid=0 is swallowed
      req_valid = 1'b1; args = 38'd0; addr = 32'h1234;
      step();
      req_valid = 1'b0;
      check("inv_req_ready", req_ready, 1);
      check("inv_dreq_valid", dreq_valid, 0);

      // SB at 0x1003
      issue(mk(1'b1, 1'b0, 3'd0, 32'h000000AB), 32'h1003);
      check("sb_dreq_valid", dreq_valid, 1);
      check("sb_req_ready", req_ready, 0);
      check("sb_strobe", dreq_strobe, 4'b1000);
      check("sb_data", dreq_data, 32'hABABABAB);
      check("sb_size", dreq_size, 0);
      check("sb_addr", dreq_addr, 32'h1003);
      ack_now(32'hFFFFFFFF);
      check("sb_resp_valid", resp_valid, 1);
      check("sb_resp_data", resp_data, 0);
      check("sb_dreq_low", dreq_valid, 0);
      handshake();
      check("sb_idle", req_ready, 1);
      check("sb_resp_gone", resp_valid, 0);

      // LB / LBU at 0x2001
      issue(mk(1'b0, 1'b1, 3'd0, 32'h0), 32'h2001);
      check("lb_strobe", dreq_strobe, 0);
      ack_now(32'h12348056);
      check("lb_resp_valid", resp_valid, 1);
      check("lb_data", resp_data, 32'hFFFFFF80);
      handshake();
      issue(mk(1'b0, 1'b0, 3'd0, 32'h0), 32'h2001);
      ack_now(32'h12348056);
      check("lbu_data", resp_data, 32'h00000080);
      handshake();

      // LH at 0x2002 with addr_ok stalls and a late data_ok
      issue(mk(1'b0, 1'b1, 3'd1, 32'h0), 32'h2002);
      for (int i = 0; i < 3; i++) begin
         check("lh_stall_valid", dreq_valid, 1);
         check("lh_stall_addr", dreq_addr, 32'h2002);
         check("lh_stall_size", dreq_size, 1);
         check("lh_stall_strobe", dreq_strobe, 0);
         dresp_data_ok = (i == 1);
         dresp_data    = 32'h77777777;
         step();
         dresp_data_ok = 1'b0;
      end
      check("lh_still_req", dreq_valid, 1);
      dresp_addr_ok = 1'b1;
      step();
      dresp_addr_ok = 1'b0;
      check("lh_wait_dreq", dreq_valid, 0);
      check("lh_wait_resp", resp_valid, 0);
      step();
      check("lh_wait2_resp", resp_valid, 0);
      dresp_data_ok = 1'b1; dresp_data = 32'h9ABC0000;
      step();
      dresp_data_ok = 1'b0; dresp_data = 32'h0;
      check("lh_resp_valid", resp_valid, 1);
      check("lh_data", resp_data, 32'hFFFF9ABC);
      handshake();

      // SH at 0x5002: upper lanes, halfword replicated
      issue(mk(1'b1, 1'b0, 3'd1, 32'h1234ABCD), 32'h5002);
      check("sh_strobe", dreq_strobe, 4'b1100);
      check("sh_data", dreq_data, 32'hABCDABCD);
      ack_now(32'h0);
      handshake();

      // SW then LW offered during a held response
      issue(mk(1'b1, 1'b0, 3'd2, 32'hDEADBEEF), 32'h3000);
      check("sw_strobe", dreq_strobe, 4'b1111);
      check("sw_data", dreq_data, 32'hDEADBEEF);
      ack_now(32'h0);
      req_valid = 1'b1; args = mk(1'b0, 1'b0, 3'd2, 32'h0); addr = 32'h3004;
      for (int i = 0; i < 2; i++) begin
         check("sw_hold_valid", resp_valid, 1);
         check("sw_hold_data", resp_data, 0);
         check("sw_hold_ready", req_ready, 0);
         step();
      end
      handshake();
      check("lw_idle_ready", req_ready, 1);
      check("lw_idle_dreq", dreq_valid, 0);
      step();
      req_valid = 1'b0; args = '0;
      check("lw_dreq_valid", dreq_valid, 1);
      check("lw_dreq_addr", dreq_addr, 32'h3004);
      check("lw_strobe", dreq_strobe, 0);
      ack_now(32'h11223344);
      check("lw_data", resp_data, 32'h11223344);
      handshake();

      // LW at 0x4002
      issue(mk(1'b0, 1'b0, 3'd2, 32'h0), 32'h4002);
`ifdef MEM_ALIGN_CHECK_EN
      check("mis_dreq_valid", dreq_valid, 0);
      check("mis_resp_valid", resp_valid, 1);
      check("mis_adel", resp_adel, 1);
      check("mis_ades", resp_ades, 0);
      check("mis_data", resp_data, 0);
      handshake();
      issue(mk(1'b1, 1'b0, 3'd1, 32'h0), 32'h4001);
      check("mis_st_resp", resp_valid, 1);
      check("mis_st_ades", resp_ades, 1);
      check("mis_st_adel", resp_adel, 0);
      handshake();
`else
      check("nomis_dreq_valid", dreq_valid, 1);
      check("nomis_addr", dreq_addr, 32'h4002);
      check("nomis_size", dreq_size, 2);
      ack_now(32'hCAFEF00D);
      check("nomis_data", resp_data, 32'hCAFEF00D);
      check("nomis_adel", resp_adel, 0);
      handshake();
`endif

      // reset while in WAIT, then a stray data_ok
      issue(mk(1'b0, 1'b0, 3'd2, 32'h0), 32'h6000);
      dresp_addr_ok = 1'b1;
      step();
      dresp_addr_ok = 1'b0;
      check("rw_in_wait", dreq_valid, 0);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check("rw_ready", req_ready, 1);
      check("rw_dreq", dreq_valid, 0);
      dresp_data_ok = 1'b1; dresp_data = 32'h87654321;
      step();
      dresp_data_ok = 1'b0;
      check("rw_no_resp", resp_valid, 0);
      check("rw_ready2", req_ready, 1);
      step();
      check("rw_no_resp2", resp_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
